// File: rtl/ram_requester_if.sv
// ram_requester_if: RAM request/response bus between ram_requester (master) and the system RAM (slave).
package ram_pkg;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

interface ram_requester_if;
    import ram_pkg::*;
    logic ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    ramstate_t ramstate;
    modport master(output ramREN, ramWEN, ramaddr, ramstore, input ramload, ramstate);
    modport slave(input ramREN, ramWEN, ramaddr, ramstore, output ramload, ramstate);
endinterface

// File: rtl/ram_requester.sv
// ram_requester: round-robin instruction/data arbiter issuing one RAM request at a time.
// Define RAM_TIMEOUT_EN to force-complete a grant with BAD after TIMEOUT cycles without ACCESS.
module ram_requester
    import ram_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter logic [31:0] BAD = 32'hBAD1BAD1
) (
    input  logic CLK,
    input  logic nRST,
    input  logic iREN,
    input  logic [31:0] iaddr,
    output logic iwait,
    output logic [31:0] iload,
    input  logic dREN,
    input  logic dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic dwait,
    output logic [31:0] dload,
    ram_requester_if.master ram,
    output logic err
);
`ifdef RAM_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int unsigned WW = $clog2(TIMEOUT + 2);
    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;
    state_t state;
    logic last_d, ren, wen;
    logic [31:0] addr, store;
    logic [WW-1:0] wdog;
    logic dboth, dreq, granted, access, tmo, done, abort, win_d;
    // A simultaneous read+write from the data client counts as no request.
    assign dboth = dREN & dWEN;
    assign dreq = dREN ^ dWEN;
    assign granted = state != IDLE;
    assign access = granted && ram.ramstate == ACCESS;
    assign tmo = TMO_EN && granted && !access && wdog == WW'(TIMEOUT);
    assign done = access || tmo;
    assign abort = !done && (state == IGRANT ? !iREN : (state == DGRANT && !dreq));
    assign win_d = dreq && (!iREN || !last_d);
    assign ram.ramREN = ren;
    assign ram.ramWEN = wen;
    assign ram.ramaddr = addr;
    assign ram.ramstore = store;
    assign iwait = !(state == IGRANT && done);
    assign dwait = !(state == DGRANT && done);
    assign iload = tmo ? BAD : ram.ramload;
    assign dload = tmo ? BAD : ram.ramload;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            last_d <= 1'b0;
            ren <= 1'b0;
            wen <= 1'b0;
            addr <= '0;
            store <= '0;
            wdog <= '0;
            err <= 1'b0;
        end else begin
            if (dboth || (granted && ram.ramstate == ERROR) || tmo) err <= 1'b1;
            if (state == IDLE) begin
                wdog <= '0;
                if (iREN || dreq) begin
                    state <= win_d ? DGRANT : IGRANT;
                    addr <= win_d ? daddr : iaddr;
                    store <= win_d ? dstore : '0;
                    ren <= win_d ? dREN : 1'b1;
                    wen <= win_d && dWEN;
                end
            end else if (done || abort) begin
                state <= IDLE;
                ren <= 1'b0;
                wen <= 1'b0;
                if (done) last_d <= state == DGRANT;
            end else begin
                wdog <= wdog + WW'(1);
            end
        end
    end
endmodule

// File: tb/tb_ram_requester.sv
// tb_ram_requester: scoreboard bench with a latency-programmable RAM model for ram_requester.
module tb_ram_requester;
    import ram_pkg::*;
    logic CLK = 0, nRST = 0;
    logic iREN = 0, dREN = 0, dWEN = 0;
    logic [31:0] iaddr = 0, daddr = 0, dstore = 0;
    logic iwait, dwait, err;
    logic [31:0] iload, dload;
    ram_requester_if ram();
    ram_requester dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .ram(ram), .err(err)
    );
    always #5 CLK = ~CLK;

    typedef struct packed {logic d; logic chk; logic [31:0] load;} exp_t;
    exp_t sbq[$];
    int n_chk = 0, n_pass = 0;
    logic [31:0] mem [logic [31:0]];
    int lat = 2, cnt = 0;
    bit hang = 0, errinj = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] rd(logic [31:0] a);
        return mem.exists(a) ? mem[a] : ~a;
    endfunction

    task automatic push(bit d, bit chk, logic [31:0] load);
        exp_t e;
        e = {d, chk, load};
        sbq.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin @(negedge CLK); n++; end while (iwait && dwait && n < 200);
        if (iwait && dwait) check("done_timeout", 0, 1);
    endtask

    // RAM model: ACCESS once a request has been held for lat cycles
    initial begin
        ram.ramstate = FREE;
        ram.ramload = 0;
    end
    always @(posedge CLK) begin
        #1;
        if (ram.ramREN || ram.ramWEN) begin
            cnt++;
            if (!hang && cnt >= lat) begin
                ram.ramstate = ACCESS;
                if (ram.ramWEN) mem[ram.ramaddr] = ram.ramstore;
            end else ram.ramstate = (errinj && cnt == 1) ? ERROR : BUSY;
        end else begin
            cnt = 0;
            ram.ramstate = FREE;
        end
        ram.ramload = rd(ram.ramaddr);
    end

    always @(negedge CLK) begin
        if (nRST && (!iwait || !dwait)) begin
            if (sbq.size() == 0) check("unexpected_wait", {30'b0, iwait, dwait}, 32'd3);
            else begin
                exp_t e;
                e = sbq.pop_front();
                check("wait_pair", {30'b0, iwait, dwait}, e.d ? 32'd2 : 32'd1);
                if (e.chk) check("load", e.d ? dload : iload, e.load);
            end
        end
    end

    initial begin
        mem[32'h40] = 32'h1234;
        repeat (2) @(negedge CLK);
        check("rst_iwait", iwait, 1);
        check("rst_dwait", dwait, 1);
        check("rst_ramREN", ram.ramREN, 0);
        check("rst_ramWEN", ram.ramWEN, 0);
        check("rst_ramaddr", ram.ramaddr, 0);
        check("rst_ramstore", ram.ramstore, 0);
        check("rst_err", err, 0);
        nRST = 1;
        @(negedge CLK);
        // instruction read
        push(0, 1, 32'h1234);
        iaddr = 32'h40; iREN = 1;
        @(negedge CLK);
        check("i_ramREN", ram.ramREN, 1);
        check("i_ramWEN", ram.ramWEN, 0);
        check("i_ramaddr", ram.ramaddr, 32'h40);
        check("i_iwait_busy", iwait, 1);
        wait_done();
        iREN = 0;
        @(negedge CLK);
        check("i_idle_ramREN", ram.ramREN, 0);
        // contention: D, I, D with an idle bubble between grants
        push(1, 1, rd(32'h100)); push(0, 1, rd(32'h40)); push(1, 1, rd(32'h100));
        iaddr = 32'h40; daddr = 32'h100; iREN = 1; dREN = 1;
        for (int k = 0; k < 3; k++) begin
            wait_done();
            if (k == 2) begin iREN = 0; dREN = 0; end
            @(negedge CLK);
            check("bubble", ram.ramREN, 0);
        end
        // data write then readback
        push(1, 0, 0);
        daddr = 32'h80; dstore = 32'hCAFE; dWEN = 1;
        @(negedge CLK);
        check("w_ramWEN", ram.ramWEN, 1);
        check("w_ramREN", ram.ramREN, 0);
        check("w_ramstore", ram.ramstore, 32'hCAFE);
        check("w_ramaddr", ram.ramaddr, 32'h80);
        wait_done();
        dWEN = 0;
        @(negedge CLK);
        push(1, 1, 32'hCAFE);
        dREN = 1;
        wait_done();
        dREN = 0;
        @(negedge CLK);
        // make last==I, then abort a data grant
        push(0, 1, rd(32'h44));
        iaddr = 32'h44; iREN = 1;
        wait_done();
        iREN = 0;
        @(negedge CLK);
        hang = 1;
        push(0, 1, rd(32'h48));
        iaddr = 32'h48; daddr = 32'h90; iREN = 1; dREN = 1;
        @(negedge CLK);
        check("ab_dwins", ram.ramaddr, 32'h90);
        repeat (2) @(negedge CLK);
        dREN = 0;
        @(negedge CLK);
        check("ab_drop", ram.ramREN, 0);
        hang = 0;
        wait_done();
        iREN = 0;
        @(negedge CLK);
        // RAM ERROR while granted: err set, access still completes
        check("err_clear", err, 0);
        errinj = 1; lat = 3;
        push(1, 1, rd(32'hA0));
        daddr = 32'hA0; dREN = 1;
        wait_done();
        dREN = 0; errinj = 0; lat = 2;
        check("err_set", err, 1);
        @(negedge CLK);
        // asynchronous reset mid-grant
        hang = 1;
        iaddr = 32'h60; iREN = 1;
        @(negedge CLK);
        check("mr_ramREN_before", ram.ramREN, 1);
        #2 nRST = 0;
        #1;
        check("mr_ramREN", ram.ramREN, 0);
        check("mr_ramaddr", ram.ramaddr, 0);
        check("mr_iwait", iwait, 1);
        check("mr_dwait", dwait, 1);
        check("mr_err", err, 0);
        iREN = 0;
        @(negedge CLK);
        nRST = 1;
        @(negedge CLK);
        // watchdog
        daddr = 32'hC0; dREN = 1;
`ifdef RAM_TIMEOUT_EN
        push(1, 1, 32'hBAD1BAD1);
        begin
            int n = 0;
            do begin @(negedge CLK); n++; end while (dwait && n < 100);
            check("wdog_cycles", n, 16);
            check("wdog_err", err, 1);
        end
        dREN = 0; hang = 0;
        @(negedge CLK);
`else
        begin
            int lows = 0;
            repeat (100) begin @(negedge CLK); if (!dwait) lows++; end
            check("no_wdog_pulse", lows, 0);
            check("no_wdog_ramREN", ram.ramREN, 1);
        end
        dREN = 0; hang = 0;
        nRST = 0;
        @(negedge CLK);
        nRST = 1;
        @(negedge CLK);
`endif
        // simultaneous dREN+dWEN is ignored and flags err
        check("db_err_before", err, TMO_BENCH());
        dREN = 1; dWEN = 1; daddr = 32'hB0;
        repeat (3) @(negedge CLK);
        check("db_ramREN", ram.ramREN, 0);
        check("db_ramWEN", ram.ramWEN, 0);
        check("db_err", err, 1);
        dREN = 0; dWEN = 0;
        repeat (2) @(negedge CLK);
        check("sb_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    function automatic logic [31:0] TMO_BENCH();
`ifdef RAM_TIMEOUT_EN
        return 32'd1;
`else
        return 32'd0;
`endif
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/ram_requester.md
# ram_requester

Initiator side of the CPU-to-RAM port. It arbitrates between the instruction-fetch client and the data client, then drives one request at a time toward the system RAM. It holds that request until the RAM reports ACCESS, and returns the result to the winning client with a one-cycle wait release. It sits between the caches/datapath and the RAM, replacing direct client-to-RAM wiring.

## Interface
Parameters:
- TIMEOUT, default 15: cycles a grant may stay outstanding without ACCESS before the watchdog fires (used only with RAM_TIMEOUT_EN).
- BAD, default 32'hBAD1BAD1: load value returned on watchdog abort.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  reset; asynchronous, active-low.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction word address; held stable while iREN is high.
- iwait  out  1  low only in the cycle the instruction access completes.
- iload  out  32  read data; valid when iwait is low.
- dREN, dWEN  in  1 each  data read/write request; mutually exclusive.
- daddr  in  32  data address; held stable while a data request is high.
- dstore  in  32  write data; held stable with dWEN.
- dwait  out  1  low only in the cycle the data access completes.
- dload  out  32  read data; valid when dwait is low.
- ramREN, ramWEN  out  1 each  request to the RAM.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  ramstate_t  RAM status: FREE, BUSY, ACCESS or ERROR.
- err  out  1  sticky fault flag.

## Operation
- FSM states: IDLE, IGRANT, DGRANT.
- Registers: state, last (the client granted most recently), latched addr/store/op, watchdog count.

IDLE:
- ramREN and ramWEN are 0.
- If only one client requests, grant it. The next state is IGRANT or DGRANT.
- If both request, the data client wins unless last==D. In that case the instruction client wins. This is round-robin when both are contending.
- At the grant edge, latch the winner's address, store data and op.

While in a GRANT state:
- Drive ramaddr, ramstore, ramREN and ramWEN from the latched values.
- When ramstate==ACCESS:
  - pull the granted client's wait low for exactly that cycle;
  - the load output equals ramload;
  - next state is IDLE and last is updated.
- If the granted client drops its request before ACCESS, abort. Next state is IDLE, no wait pulse is issued, and last is unchanged.

Other rules:
- ramstate==ERROR while granted sets err. The request continues.
- iload and dload pass ramload through in every cycle. They are meaningful only when the matching wait is low.
- iwait and dwait are 1 in every cycle except their completion cycle, including when idle.
- A simultaneous dREN and dWEN is ignored: the data client is treated as not requesting, and err is set.

## Timing
- Reset values: state=IDLE, last=I, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, err=0, watchdog=0.
- Grant latency: a request seen in cycle N drives the RAM request from cycle N+1.
- Completion is in the first cycle with ramstate==ACCESS while granted. It is at least 1 cycle after the grant.
- There is one mandatory IDLE bubble after each completion or abort. Back-to-back accesses are therefore spaced by at least 2 cycles beyond RAM latency.
- The wait low pulse is combinational from ramstate within the GRANT state and lasts exactly one cycle.
- Reset mid-grant: the state returns to IDLE asynchronously and the RAM request drops immediately. No completion is reported.
- err clears only on reset.

## Configuration
- RAM_TIMEOUT_EN defined:
  - The watchdog counts each GRANT cycle without ACCESS and clears in IDLE.
  - When the count reaches TIMEOUT, the access is force-completed: the granted wait goes low for one cycle, the load output is BAD, err is set, and next state is IDLE.
- RAM_TIMEOUT_EN undefined: there is no watchdog. A grant waits indefinitely for ACCESS.

## Test plan
- Instruction read only: iREN=1, iaddr=0x40, bench RAM gives ACCESS 2 cycles after ramREN, with ramload=0x1234 -> ramREN=1 and ramaddr=0x40 from the cycle after the request; iwait=0 for one cycle with iload=0x1234; then IDLE and ramREN=0.
- Data write: dWEN=1, daddr=0x80, dstore=0xCAFE -> ramWEN=1 with ramstore=0xCAFE; dwait pulses once on ACCESS; iwait stays 1.
- Contention: iREN and dREN both held from reset -> data granted first, then instruction, then data again, with one IDLE cycle between grants.
- Abort: dREN drops while in DGRANT before ACCESS -> RAM request drops next cycle, no dwait pulse, last unchanged (instruction granted next if pending).
- Reset mid-grant: nRST asserted while ramREN=1 -> ramREN=0 immediately and all outputs at their reset values.
- Watchdog (RAM_TIMEOUT_EN, TIMEOUT=15): RAM never reaches ACCESS -> after 15 GRANT cycles dwait=0 with dload=0xBAD1BAD1 and err=1. Without the macro, dwait remains 1 for 100 cycles.
